dist_gain: RTL

- Downstream consumer of the 4-bit distance intensity level, where 0 is far/least intense and 8 is closest.
- Debounces the intensity, then slews a gain register toward it one step at a time.
- Applies the gain to the 12-bit signed audio sample stream, so hand proximity controls volume without zipper noise.
- Sits between the distance block and the audio output path.

---
 rtl/dist_gain_if.sv | 21 ++
 rtl/dist_gain.sv | 114 +++++++++++
 2 files changed

// File: rtl/dist_gain_if.sv
// Sample stream and control/status bundle for the distance-driven gain stage.
// The master side drives intensity and samples; the slave (dist_gain) returns scaled samples and status.
interface dist_gain_if;
    logic [3:0]  intensity;
    logic        sample_valid;
    logic [11:0] sample_in;
    logic [11:0] sample_out;
    logic        out_valid;
    logic [3:0]  gain;
    logic        settled;

    modport master (
        output intensity, sample_valid, sample_in,
        input  sample_out, out_valid, gain, settled
    );

    modport slave (
        input  intensity, sample_valid, sample_in,
        output sample_out, out_valid, gain, settled
    );
endinterface

// File: rtl/dist_gain.sv
// Debounces the distance intensity, slews a 0..8 gain toward it one step per RAMP_SAMPLES
// strobes, and scales the signed audio stream by gain/8 with a two-cycle pipeline.
module dist_gain #(
    parameter int HOLD_SAMPLES = 64,
    parameter int RAMP_SAMPLES = 256
) (
    input logic       clk,
    input logic       reset,
    dist_gain_if.slave bus
);
    localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam int RW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_SAMPLES - 1);
    localparam logic [RW-1:0] RAMP_MAX = RW'(RAMP_SAMPLES - 1);

    typedef enum logic [1:0] {SETTLED, RISE, FALL} slew_state_t;

    slew_state_t state, next_state;

    logic [3:0]        gain, target, cand, ci;
    logic [HW-1:0]     stable_cnt;
    logic [RW-1:0]     ramp_cnt;
    logic signed [16:0] prod, sample_ext, gain_ext;
    logic              valid_s1;
    logic [11:0]       sample_out;
    logic              out_valid;
    logic              settled;

    always_comb begin
        ci = (bus.intensity > 4'd8) ? 4'd8 : bus.intensity;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SETTLED;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = SETTLED;
        if (gain < target) begin
            next_state = RISE;
        end else if (gain > target) begin
            next_state = FALL;
        end
    end

    always_comb begin
        settled = (state == SETTLED);
    end

    // Direction comes from the live gain/target compare so a reversal steps the new way
    // immediately and a step can never cross the target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gain       <= 4'd0;
            target     <= 4'd0;
            cand       <= 4'd0;
            stable_cnt <= '0;
            ramp_cnt   <= '0;
        end else if (bus.sample_valid) begin
            if (ci != cand) begin
                cand       <= ci;
                stable_cnt <= '0;
            end else if (stable_cnt < HOLD_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else begin
                target <= cand;
            end

            if (state == SETTLED) begin
                ramp_cnt <= '0;
            end else if (gain != target) begin
                if (ramp_cnt == RAMP_MAX) begin
                    ramp_cnt <= '0;
                    gain     <= (gain < target) ? gain + 4'd1 : gain - 4'd1;
                end else begin
                    ramp_cnt <= ramp_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sample_ext = {{5{bus.sample_in[11]}}, bus.sample_in};
        gain_ext   = {13'd0, gain};
    end

    // Gain 8 is unity, so the product shifted right by 3 always fits back into 12 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod       <= '0;
            valid_s1   <= 1'b0;
            sample_out <= 12'd0;
            out_valid  <= 1'b0;
        end else begin
            valid_s1  <= bus.sample_valid;
            out_valid <= valid_s1;
            if (bus.sample_valid) begin
                prod <= sample_ext * gain_ext;
            end
            if (valid_s1) begin
                sample_out <= 12'(prod >>> 3);
            end
        end
    end

    assign bus.gain       = gain;
    assign bus.settled    = settled;
    assign bus.sample_out = sample_out;
    assign bus.out_valid  = out_valid;
endmodule
